// File: rtl/golomb_unpacker.sv
// Golomb codeword unpacker: buffers an MSB-first word stream and decodes one
// limited-length Golomb codeword per dec_start. Optional macro GOLOMB_BITCOUNT_EN adds bits_consumed.
module golomb_unpacker #(
    parameter int pixel_length = 8,
    parameter int word_length  = 32,
    parameter int limit        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [word_length-1:0]  word_in,
    input  logic                    word_valid,
    input  logic                    EOF_in,
    output logic                    word_ready,
    input  logic [3:0]              k,
    input  logic                    dec_start,
    output logic                    dec_ready,
    output logic [pixel_length:0]   value_out,
    output logic                    value_valid,
    output logic                    escape_out,
    output logic                    format_err,
    output logic                    EOF_out
`ifdef GOLOMB_BITCOUNT_EN
    ,
    output logic [31:0]             bits_consumed
`endif
);

    localparam int BUF_W  = 2 * word_length;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam int ZC_W   = $clog2(limit + 1);
    localparam int VAL_W  = pixel_length + 1;
    localparam logic [ZC_W-1:0] ZC_MAX = ZC_W'(limit - pixel_length - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UNARY  = 2'd1,
        REMAIN = 2'd2,
        ESCAPE = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_next_s;
    logic [BUF_W-1:0]      buf_r;
    logic [BUF_W-1:0]      buf_next_s;
    logic [FILL_W-1:0]     fill_r;
    logic [FILL_W-1:0]     fill_next_s;
    logic [ZC_W-1:0]       zc_r;
    logic [ZC_W-1:0]       zc_next_s;
    logic [3:0]            k_r;
    logic [3:0]            k_next_s;
    logic [VAL_W-1:0]      value_r;
    logic [VAL_W-1:0]      value_next_s;
    logic                  value_valid_r;
    logic                  escape_r;
    logic                  escape_next_s;
    logic                  done_s;
    logic                  format_err_r;
    logic                  ferr_set_s;
    logic                  eof_flag_r;
    logic                  accept_s;
    logic                  word_ready_s;
    logic [FILL_W-1:0]     consume_s;
    logic [FILL_W-1:0]     remain_cnt_s;
    logic [BUF_W-1:0]      shifted_s;
    logic [BUF_W-1:0]      word_aligned_s;
    logic [15:0]           top16_s;
    logic [4:0]            rem_shamt_s;
    logic [15:0]           rem_bits_s;
    logic [31:0]           rem_wide_s;
    logic [pixel_length-1:0] esc_bits_s;

    // Head-of-buffer field extraction for the REMAIN and ESCAPE steps
    always_comb begin
        top16_s     = buf_r[BUF_W-1 -: 16];
        rem_shamt_s = 5'd16 - {1'b0, k_r};
        rem_bits_s  = top16_s >> rem_shamt_s;
        rem_wide_s  = (32'(zc_r) << k_r) | {16'd0, rem_bits_s};
        esc_bits_s  = buf_r[BUF_W-1 -: pixel_length];
    end

    // Decoder next-state, bit consumption and result computation
    always_comb begin
        state_next_s  = state_r;
        zc_next_s     = zc_r;
        k_next_s      = k_r;
        consume_s     = {FILL_W{1'b0}};
        value_next_s  = value_r;
        escape_next_s = escape_r;
        done_s        = 1'b0;
        ferr_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (dec_start) begin
                    k_next_s     = k;
                    zc_next_s    = {ZC_W{1'b0}};
                    state_next_s = UNARY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            UNARY: begin
                if (fill_r != {FILL_W{1'b0}}) begin
                    consume_s = FILL_W'(1);
                    if (buf_r[BUF_W-1] == 1'b0) begin
                        // a zero beyond the escape threshold cannot form a legal codeword
                        if (zc_r == ZC_MAX) begin
                            ferr_set_s   = 1'b1;
                            state_next_s = IDLE;
                        end else begin
                            zc_next_s = zc_r + ZC_W'(1);
                        end
                    end else if (zc_r == ZC_MAX) begin
                        state_next_s = ESCAPE;
                    end else begin
                        state_next_s = REMAIN;
                    end
                end else begin
                    state_next_s = UNARY;
                end
            end
            REMAIN: begin
                if (fill_r >= FILL_W'(k_r)) begin
                    consume_s     = FILL_W'(k_r);
                    value_next_s  = rem_wide_s[VAL_W-1:0];
                    escape_next_s = 1'b0;
                    done_s        = 1'b1;
                    state_next_s  = IDLE;
                end else begin
                    state_next_s = REMAIN;
                end
            end
            ESCAPE: begin
                if (fill_r >= FILL_W'(pixel_length)) begin
                    consume_s     = FILL_W'(pixel_length);
                    value_next_s  = VAL_W'(esc_bits_s) + VAL_W'(1);
                    escape_next_s = 1'b1;
                    done_s        = 1'b1;
                    state_next_s  = IDLE;
                end else begin
                    state_next_s = ESCAPE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Bit buffer: drop consumed bits, then append an accepted word below the survivors
    always_comb begin
        word_ready_s   = (fill_r <= FILL_W'(word_length)) && !eof_flag_r;
        accept_s       = word_valid && word_ready_s;
        remain_cnt_s   = fill_r - consume_s;
        shifted_s      = buf_r << consume_s;
        word_aligned_s = {word_in, {word_length{1'b0}}};
        if (accept_s) begin
            buf_next_s  = shifted_s | (word_aligned_s >> remain_cnt_s);
            fill_next_s = remain_cnt_s + FILL_W'(word_length);
        end else begin
            buf_next_s  = shifted_s;
            fill_next_s = remain_cnt_s;
        end
    end

    // State, buffer and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            buf_r         <= {BUF_W{1'b0}};
            fill_r        <= {FILL_W{1'b0}};
            zc_r          <= {ZC_W{1'b0}};
            k_r           <= 4'd0;
            value_r       <= {VAL_W{1'b0}};
            value_valid_r <= 1'b0;
            escape_r      <= 1'b0;
            format_err_r  <= 1'b0;
            eof_flag_r    <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            buf_r         <= buf_next_s;
            fill_r        <= fill_next_s;
            zc_r          <= zc_next_s;
            k_r           <= k_next_s;
            value_r       <= value_next_s;
            value_valid_r <= done_s;
            escape_r      <= escape_next_s;
            format_err_r  <= format_err_r | ferr_set_s;
            eof_flag_r    <= eof_flag_r | (accept_s && EOF_in);
        end
    end

`ifdef GOLOMB_BITCOUNT_EN
    logic [31:0] bits_consumed_r;

    // Running total of consumed bits, wraps naturally at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            bits_consumed_r <= 32'd0;
        end else begin
            bits_consumed_r <= bits_consumed_r + 32'(consume_s);
        end
    end

    assign bits_consumed = bits_consumed_r;
`endif

    assign word_ready  = word_ready_s;
    assign dec_ready   = (state_r == IDLE);
    assign value_out   = value_r;
    assign value_valid = value_valid_r;
    assign escape_out  = escape_r;
    assign format_err  = format_err_r;
    assign EOF_out     = eof_flag_r && (fill_r == {FILL_W{1'b0}}) && (state_r == IDLE);

endmodule

// File: tb/tb_golomb_unpacker.sv
// Directed bench for golomb_unpacker with hand-computed codeword results.
module tb_golomb_unpacker;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] word_in = 32'd0;
    logic        word_valid = 1'b0;
    logic        EOF_in = 1'b0;
    logic        word_ready;
    logic [3:0]  k = 4'd0;
    logic        dec_start = 1'b0;
    logic        dec_ready;
    logic [8:0]  value_out;
    logic        value_valid;
    logic        escape_out;
    logic        format_err;
    logic        EOF_out;
`ifdef GOLOMB_BITCOUNT_EN
    logic [31:0] bits_consumed;
`endif

    int checks = 0;
    int errors = 0;

    golomb_unpacker #(.pixel_length(8), .word_length(32), .limit(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .word_in     (word_in),
        .word_valid  (word_valid),
        .EOF_in      (EOF_in),
        .word_ready  (word_ready),
        .k           (k),
        .dec_start   (dec_start),
        .dec_ready   (dec_ready),
        .value_out   (value_out),
        .value_valid (value_valid),
        .escape_out  (escape_out),
        .format_err  (format_err),
        .EOF_out     (EOF_out)
`ifdef GOLOMB_BITCOUNT_EN
        ,
        .bits_consumed (bits_consumed)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w, input logic eof, input string tag);
        int n = 0;
        word_in = w;
        EOF_in = eof;
        word_valid = 1'b1;
        while (word_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_accept"}, {31'd0, word_ready}, 32'd1);
        @(posedge clk); #1;
        word_valid = 1'b0;
        EOF_in = 1'b0;
    endtask

    task automatic decode(input logic [3:0] kv, input logic [8:0] ev, input logic ee,
                          input int ecyc, input string tag);
        int cnt;
        k = kv;
        dec_start = 1'b1;
        @(posedge clk); #1;
        dec_start = 1'b0;
        cnt = 1;
        while (value_valid !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({tag, "_valid"}, {31'd0, value_valid}, 32'd1);
        check({tag, "_value"}, {23'd0, value_out}, {23'd0, ev});
        check({tag, "_escape"}, {31'd0, escape_out}, {31'd0, ee});
        if (ecyc > 0) check({tag, "_latency"}, cnt, ecyc);
    endtask

    initial begin
        int cnt;
        logic saw_valid;

        // reset values
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_dec_ready", {31'd0, dec_ready}, 32'd1);
        check("rst_word_ready", {31'd0, word_ready}, 32'd1);
        check("rst_value_valid", {31'd0, value_valid}, 32'd0);
        check("rst_value_out", {23'd0, value_out}, 32'd0);
        check("rst_escape", {31'd0, escape_out}, 32'd0);
        check("rst_format_err", {31'd0, format_err}, 32'd0);
        check("rst_eof_out", {31'd0, EOF_out}, 32'd0);
        reset = 1'b0;

        // k=2, 0011 0... -> two zeros, remainder 10 -> 10
        push_word(32'h3000_0000, 1'b0, "w1");
        decode(4'd2, 9'd10, 1'b0, 5, "k2");
        @(posedge clk); #1;
        check("k2_pulse_low", {31'd0, value_valid}, 32'd0);
        check("k2_value_hold", {23'd0, value_out}, 32'd10);

        // k=0, leading one -> 0
        apply_reset();
        push_word(32'h8000_0000, 1'b0, "w2");
        decode(4'd0, 9'd0, 1'b0, 3, "k0");

        // escape codeword, last word of stream
        apply_reset();
        push_word(32'h0000_01FF, 1'b1, "w3");
        check("eof_pending", {31'd0, EOF_out}, 32'd0);
        check("eof_word_ready", {31'd0, word_ready}, 32'd0);
        decode(4'd5, 9'd256, 1'b1, 26, "esc");
        check("eof_out", {31'd0, EOF_out}, 32'd1);

        // 28 one-bit codewords then one spanning the word boundary
        apply_reset();
        push_word(32'hFFFF_FFF0, 1'b0, "w4a");
        push_word(32'h0800_0000, 1'b0, "w4b");
        check("full_word_ready", {31'd0, word_ready}, 32'd0);
        for (int i = 0; i < 28; i++) begin
            decode(4'd0, 9'd0, 1'b0, 3, "run0");
        end
        decode(4'd0, 9'd8, 1'b0, 11, "span");

        // 27 zeros left plus a zero word -> unary overflow after 24 zeros
        push_word(32'h0000_0000, 1'b0, "w5");
        k = 4'd3;
        dec_start = 1'b1;
        @(posedge clk); #1;
        dec_start = 1'b0;
        cnt = 1;
        saw_valid = 1'b0;
        while (format_err !== 1'b1 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
            if (value_valid === 1'b1) saw_valid = 1'b1;
        end
        check("ferr_set", {31'd0, format_err}, 32'd1);
        check("ferr_latency", cnt, 25);
        check("ferr_no_valid", {31'd0, saw_valid}, 32'd0);
        check("ferr_idle", {31'd0, dec_ready}, 32'd1);
        check("ferr_value_hold", {23'd0, value_out}, 32'd8);

        // reset in UNARY discards partial codeword and the remaining zeros
        dec_start = 1'b1;
        @(posedge clk); #1;
        dec_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", {31'd0, dec_ready}, 32'd0);
        apply_reset();
        check("mid_dec_ready", {31'd0, dec_ready}, 32'd1);
        check("mid_word_ready", {31'd0, word_ready}, 32'd1);
        check("mid_value_out", {23'd0, value_out}, 32'd0);
        check("mid_value_valid", {31'd0, value_valid}, 32'd0);
        check("mid_format_err", {31'd0, format_err}, 32'd0);
        check("mid_escape", {31'd0, escape_out}, 32'd0);
        check("mid_eof_out", {31'd0, EOF_out}, 32'd0);
        // 0 1 1 with k=1 -> (1<<1)|1 = 3, only if stale zeros were dropped
        push_word(32'h6000_0000, 1'b0, "w6");
        decode(4'd1, 9'd3, 1'b0, 4, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/golomb_unpacker.md
GOLOMB_UNPACKER -- requirements
Module: golomb_unpacker

Interface
REQ-001 SHALL provide parameter pixel_length, default 8, quantized sample bit depth (qbpp).
REQ-002 SHALL provide parameter word_length, default 32, width of input bitstream words.
REQ-003 SHALL provide parameter limit, default 32, maximum Golomb codeword length (LIMIT).
REQ-004 SHALL have exactly one clock; reset is synchronous and active-high; ports are named clk and reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 word_in  input  word_length  bitstream word, MSB first.
REQ-008 word_valid  input  1  word_in is valid.
REQ-009 EOF_in  input  1  qualifies word_in as the last word of the stream.
REQ-010 word_ready  output  1  block accepts word_in this cycle.
REQ-011 k  input  4  Golomb parameter, sampled on accepted dec_start.
REQ-012 dec_start  input  1  request to decode one codeword.
REQ-013 dec_ready  output  1  block is idle and can accept dec_start.
REQ-014 value_out  output  pixel_length+1  decoded mapped error value (MErrval).
REQ-015 value_valid  output  1  one-cycle pulse qualifying value_out.
REQ-016 escape_out  output  1  value_out came from a limited-length (escape) codeword; valid with value_valid.
REQ-017 format_err  output  1  sticky error flag: unary prefix overflow.
REQ-018 EOF_out  output  1  level: final word accepted, buffer empty, block idle.

Function
REQ-019 SHALL keep a 2*word_length-bit MSB-aligned bit buffer with fill count 0..2*word_length.
REQ-020 word_ready SHALL be high when fill <= word_length; a word is accepted when word_valid && word_ready and is appended below the existing bits.
REQ-021 Refill and bit consumption SHALL be allowed in the same cycle; the new fill = fill + word_length - consumed.
REQ-022 The FSM SHALL have states IDLE, UNARY, REMAIN, ESCAPE.
REQ-023 IDLE: dec_ready=1; on dec_start, latch k, clear zero count, go to UNARY; dec_start in any other state SHALL be ignored.
REQ-024 UNARY: when fill>=1, consume one bit per cycle; on '0', increment zero count; on '1', go to ESCAPE if zero count == limit-pixel_length-1, else to REMAIN; when fill==0, hold state.
REQ-025 UNARY: '0' received with zero count already == limit-pixel_length-1 SHALL set format_err and return to IDLE without value_valid.
REQ-026 REMAIN: when fill>=k, consume k bits in one cycle, value = (zero count << k) | bits, truncated to pixel_length+1 bits, return to IDLE; k=0 consumes nothing and completes in one cycle.
REQ-027 ESCAPE: when fill>=pixel_length, consume pixel_length bits, value = bits + 1, escape_out=1, return to IDLE.
REQ-028 value_out/escape_out SHALL be registered; value_valid SHALL pulse high the cycle after REMAIN/ESCAPE completes; value_out holds until the next completion.
REQ-029 Latency from accepted dec_start, with data buffered: n+1 UNARY cycles (n zeros) + 1 REMAIN/ESCAPE cycle; value_valid follows one cycle later.
REQ-030 The EOF flag SHALL latch when a word with EOF_in is accepted; EOF_out = EOF flag && fill==0 && IDLE.
REQ-031 After the EOF flag is latched, word_ready SHALL stay low.

Reset
REQ-032 On reset: state IDLE, fill=0, buffer=0, zero count=0, value_out=0, value_valid=0, escape_out=0, format_err=0, EOF flag=0, word_ready=1, dec_ready=1.
REQ-033 Reset mid-decode SHALL discard all buffered bits and the partial codeword.

Configuration
REQ-034 Macro GOLOMB_BITCOUNT_EN defined: SHALL add output bits_consumed (32 bits), reset to 0, incremented by the number of bits consumed each cycle, wrapping modulo 2^32.
REQ-035 GOLOMB_BITCOUNT_EN undefined: the bits_consumed port and its counter SHALL NOT exist.

Verification
REQ-036 k=2, word 0x30000000, dec_start -> value_out=10, escape_out=0, 5 bits consumed, value_valid 5 cycles after dec_start.
REQ-037 k=0, word 0x80000000 -> value_out=0, 1 bit consumed.
REQ-038 Word 0x000001FF -> escape_out=1, value_out=256, all 32 bits consumed.
REQ-039 k=0, words 0xFFFFFFF0 then 0x08000000 -> 28 values of 0, then value 8 across the word boundary.
REQ-040 Word 0x00000000 -> format_err=1 after 24 zeros, no value_valid, then IDLE.
REQ-041 Reset asserted in UNARY -> next cycle all outputs at reset values, fill=0.
